// File: rtl/pointwise_mult_ctrl_pkg.sv
// Shared types and helpers for the pointwise multiplication controller.
package pointwise_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pwm_state_e;

  // Issue-to-write latency: BRAM read, one operand register, butterfly.
  function automatic int pwm_pipe_lat(input int rd_lat, input int bf_lat);
    return rd_lat + 1 + bf_lat;
  endfunction

endpackage

// File: rtl/DelayRegisterReset.sv
// Fixed-depth shift register for a {valid, data} pair; reset drops every
// in-flight valid (and zeroes the data) so no stale write can escape.
module DelayRegisterReset #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];

  // Shift valid and data one stage per cycle; reset empties the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_data[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

endmodule

// File: rtl/pointwise_mult_ctrl.sv
// Pointwise modular multiplication controller. Borrows butterflies 0 and 2
// (rst_pwm low), streams A/B from BRAM into them and writes results back.
// Optional feature macro: PWM_ACCUMULATE_EN adds the accumulate input and the
// c_lane0/c_lane1 ports so the result becomes C + A*B.
module pointwise_mult_ctrl
  import pointwise_mult_ctrl_pkg::*;
#(
  parameter int N           = 8192,
  parameter int LOGQ_MAX    = 54,
  parameter int ADDR_WIDTH  = $clog2(N) - 1,
  parameter int BRAM_RD_LAT = 2,
  parameter int BF_LAT      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef PWM_ACCUMULATE_EN
  input  logic                  accumulate,
  input  logic [LOGQ_MAX-1:0]   c_lane0,
  input  logic [LOGQ_MAX-1:0]   c_lane1,
`endif
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LOGQ_MAX-1:0]   a_lane0,
  input  logic [LOGQ_MAX-1:0]   a_lane1,
  input  logic [LOGQ_MAX-1:0]   b_lane0,
  input  logic [LOGQ_MAX-1:0]   b_lane1,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [LOGQ_MAX-1:0]   wr_data0,
  output logic [LOGQ_MAX-1:0]   wr_data1,
  output logic                  wea,
  output logic                  rst_pwm,
  output logic [LOGQ_MAX-1:0]   pwm_bf0_ina,
  output logic [LOGQ_MAX-1:0]   pwm_bf0_inb,
  output logic [LOGQ_MAX-1:0]   pwm_bf0_tw,
  output logic [LOGQ_MAX-1:0]   pwm_bf2_ina,
  output logic [LOGQ_MAX-1:0]   pwm_bf2_inb,
  output logic [LOGQ_MAX-1:0]   pwm_bf2_tw,
  input  logic [LOGQ_MAX-1:0]   pwm_bf0_result,
  input  logic [LOGQ_MAX-1:0]   pwm_bf2_result,
  output logic                  busy,
  output logic                  done
);

  localparam int L     = pwm_pipe_lat(BRAM_RD_LAT, BF_LAT);
  localparam int CNT_W = $clog2(L + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N / 2 - 1);

  pwm_state_e            r_state;
  pwm_state_e            w_next;
  logic                  w_accept;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [CNT_W-1:0]      r_drain_cnt;
  logic                  w_wr_vld;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [LOGQ_MAX-1:0]   r_bf0_inb;
  logic [LOGQ_MAX-1:0]   r_bf0_tw;
  logic [LOGQ_MAX-1:0]   r_bf2_inb;
  logic [LOGQ_MAX-1:0]   r_bf2_tw;

  // State register; reset overrides a coincident start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: one address per RUN cycle, then drain the pipeline.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (r_rd_addr == LAST_ADDR) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read address counter (parks at the last address) and drain countdown;
  // the countdown runs L-1..0 so the last write lands in the final DRAIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept) r_rd_addr <= '0;
      else if (r_state == S_RUN && r_rd_addr != LAST_ADDR) r_rd_addr <= r_rd_addr + 1'b1;
      if (r_state == S_RUN) r_drain_cnt <= CNT_W'(L - 1);
      else if (r_state == S_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Operand register stage: lane 0 feeds butterfly 0, lane 1 feeds butterfly 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bf0_inb <= '0;
      r_bf0_tw  <= '0;
      r_bf2_inb <= '0;
      r_bf2_tw  <= '0;
    end else begin
      r_bf0_inb <= a_lane0;
      r_bf0_tw  <= b_lane0;
      r_bf2_inb <= a_lane1;
      r_bf2_tw  <= b_lane1;
    end
  end

`ifdef PWM_ACCUMULATE_EN
  logic                r_acc;
  logic [LOGQ_MAX-1:0] r_bf0_ina;
  logic [LOGQ_MAX-1:0] r_bf2_ina;

  // Accumulate mode is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst)           r_acc <= 1'b0;
    else if (w_accept) r_acc <= accumulate;
  end

  // Addend register, aligned with the A/B operand stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bf0_ina <= '0;
      r_bf2_ina <= '0;
    end else begin
      r_bf0_ina <= r_acc ? c_lane0 : '0;
      r_bf2_ina <= r_acc ? c_lane1 : '0;
    end
  end

  assign pwm_bf0_ina = r_bf0_ina;
  assign pwm_bf2_ina = r_bf2_ina;
`else
  assign pwm_bf0_ina = '0;
  assign pwm_bf2_ina = '0;
`endif

  // Carries each issued address alongside its valid to the write port.
  DelayRegisterReset #(
    .WIDTH(ADDR_WIDTH),
    .DEPTH(L)
  ) u_wr_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w_issue),
    .in_data  (r_rd_addr),
    .out_valid(w_wr_vld),
    .out_data (w_wr_addr)
  );

  assign rd_addr     = r_rd_addr;
  assign pwm_bf0_inb = r_bf0_inb;
  assign pwm_bf0_tw  = r_bf0_tw;
  assign pwm_bf2_inb = r_bf2_inb;
  assign pwm_bf2_tw  = r_bf2_tw;
  assign wea         = w_wr_vld;
  assign wr_addr     = w_wr_addr;
  assign wr_data0    = pwm_bf0_result;
  assign wr_data1    = pwm_bf2_result;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign rst_pwm     = ~busy;
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_pointwise_mult_ctrl.sv
// Bench for pointwise_mult_ctrl: three instances (BF_LAT 10, 1, 20) with
// BRAM and butterfly models, scoreboard of expected writes per instance.
module tb_pointwise_mult_ctrl;

  localparam int N    = 16;
  localparam int HALF = N / 2;
  localparam int AW   = 3;
  localparam int LQ   = 54;
  localparam int RDL  = 2;
  localparam int Q    = 97;
  localparam int NI   = 3;

  function automatic int bfl(input int i);
    return (i == 0) ? 10 : ((i == 1) ? 1 : 20);
  endfunction
  function automatic int lat(input int i);
    return RDL + 1 + bfl(i);
  endfunction

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [LQ-1:0] d0;
    logic [LQ-1:0] d1;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
`ifdef PWM_ACCUMULATE_EN
  logic acc_in = 1'b0;
`endif
  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [LQ-1:0] memA0 [HALF];
  logic [LQ-1:0] memA1 [HALF];
  logic [LQ-1:0] memB0 [HALF];
  logic [LQ-1:0] memB1 [HALF];
  logic [LQ-1:0] memC0 [HALF];
  logic [LQ-1:0] memC1 [HALF];

  logic [AW-1:0] rd_addr_g [NI];
  logic [AW-1:0] wr_addr_g [NI];
  logic [LQ-1:0] wd0_g [NI];
  logic [LQ-1:0] wd1_g [NI];
  logic [LQ-1:0] ops_g [NI];
  logic [LQ-1:0] ina_g [NI];
  logic          wea_g [NI];
  logic          rp_g  [NI];
  logic          bz_g  [NI];
  logic          dn_g  [NI];

  exp_t sb [NI][$];

  function automatic logic [LQ-1:0] bf_model(input logic [LQ-1:0] c, input logic [LQ-1:0] a,
                                             input logic [LQ-1:0] b);
    longint t;
    t = (longint'(c) + longint'(a) * longint'(b)) % longint'(Q);
    return LQ'(t);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int BL = (g == 0) ? 10 : ((g == 1) ? 1 : 20);
    logic [AW-1:0] ra, wa;
    logic [LQ-1:0] pa0, pa1, pb0, pb1, a0, a1, b0, b1;
    logic [LQ-1:0] ina0, inb0, tw0, ina2, inb2, tw2, wd0, wd1;
    logic          we, rp, bz, dn;
    logic [LQ-1:0] bp0 [BL];
    logic [LQ-1:0] bp2 [BL];
`ifdef PWM_ACCUMULATE_EN
    logic [LQ-1:0] pc0, pc1, c0, c1;
    always @(posedge clk) begin
      pc0 <= memC0[ra];
      pc1 <= memC1[ra];
      c0  <= pc0;
      c1  <= pc1;
    end
`endif

    always @(posedge clk) begin
      pa0 <= memA0[ra];
      pa1 <= memA1[ra];
      pb0 <= memB0[ra];
      pb1 <= memB1[ra];
      a0  <= pa0;
      a1  <= pa1;
      b0  <= pb0;
      b1  <= pb1;
      bp0[0] <= bf_model(ina0, inb0, tw0);
      bp2[0] <= bf_model(ina2, inb2, tw2);
      for (int i = 1; i < BL; i++) begin
        bp0[i] <= bp0[i-1];
        bp2[i] <= bp2[i-1];
      end
    end

    pointwise_mult_ctrl #(
      .N(N), .LOGQ_MAX(LQ), .ADDR_WIDTH(AW), .BRAM_RD_LAT(RDL), .BF_LAT(BL)
    ) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef PWM_ACCUMULATE_EN
      .accumulate(acc_in), .c_lane0(c0), .c_lane1(c1),
`endif
      .rd_addr(ra), .a_lane0(a0), .a_lane1(a1), .b_lane0(b0), .b_lane1(b1),
      .wr_addr(wa), .wr_data0(wd0), .wr_data1(wd1), .wea(we), .rst_pwm(rp),
      .pwm_bf0_ina(ina0), .pwm_bf0_inb(inb0), .pwm_bf0_tw(tw0),
      .pwm_bf2_ina(ina2), .pwm_bf2_inb(inb2), .pwm_bf2_tw(tw2),
      .pwm_bf0_result(bp0[BL-1]), .pwm_bf2_result(bp2[BL-1]),
      .busy(bz), .done(dn)
    );

    assign rd_addr_g[g] = ra;
    assign wr_addr_g[g] = wa;
    assign wd0_g[g]     = wd0;
    assign wd1_g[g]     = wd1;
    assign ops_g[g]     = ina0 | inb0 | tw0 | ina2 | inb2 | tw2;
    assign ina_g[g]     = ina0 | ina2;
    assign wea_g[g]     = we;
    assign rp_g[g]      = rp;
    assign bz_g[g]      = bz;
    assign dn_g[g]      = dn;
  end

  task automatic set_pattern(input int p);
    for (int k = 0; k < HALF; k++) begin
      case (p)
        0: begin
          memA0[k] = LQ'(k + 1); memA1[k] = LQ'(k + 1); memB0[k] = 2; memB1[k] = 2;
          memC0[k] = 0; memC1[k] = 0;
        end
        1: begin
          memA0[k] = LQ'(3 * k + 5); memA1[k] = LQ'(k * k + 1); memB0[k] = 7;
          memB1[k] = LQ'(11 + k); memC0[k] = LQ'(40 + k); memC1[k] = LQ'(k);
        end
        2: begin
          memA0[k] = 1; memA1[k] = LQ'(k); memB0[k] = 1; memB1[k] = 3;
          memC0[k] = 96; memC1[k] = LQ'(90 + k);
        end
        default: begin
          memA0[k] = LQ'(50 + 6 * k); memA1[k] = LQ'(95 - k); memB0[k] = LQ'(60 + k);
          memB1[k] = LQ'(33 + 2 * k); memC0[k] = 5; memC1[k] = 7;
        end
      endcase
    end
  endtask

  // Scoreboard push: expected write for every address of one run.
  task automatic push_run(input int inst, input int t, input bit acc);
    exp_t e;
    for (int k = 0; k < HALF; k++) begin
      e.cyc  = t + 1 + k + lat(inst);
      e.addr = AW'(k);
      e.d0   = LQ'((longint'(acc ? memC0[k] : '0) + longint'(memA0[k]) * longint'(memB0[k])) % Q);
      e.d1   = LQ'((longint'(acc ? memC1[k] : '0) + longint'(memA1[k]) * longint'(memB1[k])) % Q);
      sb[inst].push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bz_g[0] || bz_g[1] || bz_g[2] || dn_g[0] || dn_g[1] || dn_g[2]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    set_pattern(1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++; if (rp_g[i] !== 1'b1) begin errors++; $display("FAIL reset_rst_pwm[%0d]: got %0b required 1", i, rp_g[i]); end
      checks++; if (wea_g[i] !== 1'b0) begin errors++; $display("FAIL reset_wea[%0d]: got %0b required 0", i, wea_g[i]); end
      checks++; if (dn_g[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %0b required 0", i, dn_g[i]); end
      checks++; if (bz_g[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %0b required 0", i, bz_g[i]); end
      checks++; if (rd_addr_g[i] !== '0) begin errors++; $display("FAIL reset_rd_addr[%0d]: got %0d required 0", i, rd_addr_g[i]); end
      checks++; if (wr_addr_g[i] !== '0) begin errors++; $display("FAIL reset_wr_addr[%0d]: got %0d required 0", i, wr_addr_g[i]); end
      checks++; if (ops_g[i] !== '0) begin errors++; $display("FAIL reset_operands[%0d]: got %0h required 0", i, ops_g[i]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t, end_c, nwe, ndone;
    logic exp_rp;
    exp_t e;
    set_pattern(0);
    start = 1'b1; t = cyc; push_run(0, t, 1'b0);
    @(negedge clk);
    start = 1'b0;
    end_c = t + HALF + lat(0) + 3; nwe = 0; ndone = 0;
    while (cyc <= end_c) begin
      exp_rp = !(cyc >= t + 1 && cyc <= t + HALF + lat(0));
      checks++; if (rp_g[0] !== exp_rp) begin errors++; $display("FAIL basic_rst_pwm @%0d: got %0b required %0b", cyc - t, rp_g[0], exp_rp); end
      checks++; if (bz_g[0] !== !exp_rp) begin errors++; $display("FAIL basic_busy @%0d: got %0b required %0b", cyc - t, bz_g[0], !exp_rp); end
      checks++; if (dn_g[0] !== (cyc == t + HALF + lat(0) + 1)) begin errors++; $display("FAIL basic_done @%0d: got %0b", cyc - t, dn_g[0]); end
      if (dn_g[0]) ndone++;
      if (cyc >= t + 1 && cyc <= t + HALF) begin
        checks++; if (rd_addr_g[0] !== AW'(cyc - t - 1)) begin errors++; $display("FAIL basic_rd_addr @%0d: got %0d required %0d", cyc - t, rd_addr_g[0], cyc - t - 1); end
      end
      if (wea_g[0]) begin
        nwe++;
        checks++;
        if (sb[0].size() == 0) begin errors++; $display("FAIL basic_extra_wea @%0d: got write with empty scoreboard", cyc - t); end
        else begin
          e = sb[0].pop_front();
          if (cyc !== e.cyc || wr_addr_g[0] !== e.addr || wd0_g[0] !== e.d0 || wd1_g[0] !== e.d1) begin
            errors++;
            $display("FAIL basic_write: got cyc=%0d addr=%0d d0=%0d d1=%0d required cyc=%0d addr=%0d d0=%0d d1=%0d",
                     cyc - t, wr_addr_g[0], wd0_g[0], wd1_g[0], e.cyc - t, e.addr, e.d0, e.d1);
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (nwe != HALF) begin errors++; $display("FAIL basic_wea_count: got %0d required %0d", nwe, HALF); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", ndone); end
    checks++; if (sb[0].size() != 0) begin errors++; $display("FAIL basic_missing_writes: got %0d left required 0", sb[0].size()); sb[0].delete(); end
  endtask

  task automatic test_start_during_run();
    int t, end_c, nwe, ndone;
    exp_t e;
    set_pattern(1);
    start = 1'b1; t = cyc; push_run(0, t, 1'b0);
    @(negedge clk);
    start = 1'b0;
    end_c = t + HALF + lat(0) + 6; nwe = 0; ndone = 0;
    while (cyc <= end_c) begin
      start = (cyc == t + 3);
      if (dn_g[0]) begin
        ndone++;
        checks++; if (cyc != t + HALF + lat(0) + 1) begin errors++; $display("FAIL ignore_done_cycle: got %0d required %0d", cyc - t, HALF + lat(0) + 1); end
      end
      if (wea_g[0]) begin
        nwe++;
        checks++;
        if (sb[0].size() == 0) begin errors++; $display("FAIL ignore_extra_wea @%0d: got write with empty scoreboard", cyc - t); end
        else begin
          e = sb[0].pop_front();
          if (cyc !== e.cyc || wr_addr_g[0] !== e.addr || wd0_g[0] !== e.d0 || wd1_g[0] !== e.d1) begin
            errors++;
            $display("FAIL ignore_write: got cyc=%0d addr=%0d d0=%0d d1=%0d required cyc=%0d addr=%0d d0=%0d d1=%0d",
                     cyc - t, wr_addr_g[0], wd0_g[0], wd1_g[0], e.cyc - t, e.addr, e.d0, e.d1);
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (nwe != HALF) begin errors++; $display("FAIL ignore_wea_count: got %0d required %0d", nwe, HALF); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d required 1", ndone); end
    sb[0].delete();
  endtask

  task automatic test_reset_mid_run();
    int t, end_c, nwe, ndone;
    exp_t e;
    set_pattern(0);
    start = 1'b1; t = cyc;
    @(negedge clk);
    start = 1'b0;
    end_c = t + 6 + lat(2) + 4;
    while (cyc <= end_c) begin
      rst = (cyc == t + 5);
      if (cyc == t + 6) begin
        for (int i = 0; i < NI; i++) begin
          checks++; if (rp_g[i] !== 1'b1) begin errors++; $display("FAIL midrst_rst_pwm[%0d]: got %0b required 1", i, rp_g[i]); end
          checks++; if (bz_g[i] !== 1'b0) begin errors++; $display("FAIL midrst_busy[%0d]: got %0b required 0", i, bz_g[i]); end
        end
      end
      if (cyc >= t + 6) begin
        for (int i = 0; i < NI; i++) begin
          checks++; if (wea_g[i] !== 1'b0 || dn_g[i] !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d] @%0d: got wea=%0b done=%0b required 0", i, cyc - t, wea_g[i], dn_g[i]); end
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    set_pattern(3);
    start = 1'b1; t = cyc; push_run(0, t, 1'b0);
    @(negedge clk);
    start = 1'b0;
    end_c = t + HALF + lat(0) + 3; nwe = 0; ndone = 0;
    while (cyc <= end_c) begin
      if (dn_g[0]) ndone++;
      if (wea_g[0]) begin
        nwe++;
        checks++;
        if (sb[0].size() == 0) begin errors++; $display("FAIL rerun_extra_wea @%0d: got write with empty scoreboard", cyc - t); end
        else begin
          e = sb[0].pop_front();
          if (cyc !== e.cyc || wr_addr_g[0] !== e.addr || wd0_g[0] !== e.d0 || wd1_g[0] !== e.d1) begin
            errors++;
            $display("FAIL rerun_write: got cyc=%0d addr=%0d d0=%0d d1=%0d required cyc=%0d addr=%0d d0=%0d d1=%0d",
                     cyc - t, wr_addr_g[0], wd0_g[0], wd1_g[0], e.cyc - t, e.addr, e.d0, e.d1);
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (nwe != HALF) begin errors++; $display("FAIL rerun_wea_count: got %0d required %0d", nwe, HALF); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL rerun_done_count: got %0d required 1", ndone); end
    sb[0].delete();
  endtask

  task automatic test_accumulate();
    int t, end_c, nwe, nruns;
    bit acc;
    exp_t e;
`ifdef PWM_ACCUMULATE_EN
    nruns = 2;
`else
    nruns = 1;
`endif
    set_pattern(2);
    for (int r = 0; r < nruns; r++) begin
      acc = (nruns == 2) && (r == 0);
`ifdef PWM_ACCUMULATE_EN
      acc_in = acc;
`endif
      start = 1'b1; t = cyc; push_run(0, t, acc);
      @(negedge clk);
      start = 1'b0;
`ifdef PWM_ACCUMULATE_EN
      acc_in = 1'b0;
`endif
      end_c = t + HALF + lat(0) + 1; nwe = 0;
      while (cyc <= end_c) begin
        if (!acc && cyc >= t + 1 + RDL + 1 && cyc <= t + HALF + RDL + 1) begin
          checks++; if (ina_g[0] !== '0) begin errors++; $display("FAIL acc_ina_zero @%0d: got %0d required 0", cyc - t, ina_g[0]); end
        end
        if (wea_g[0]) begin
          nwe++;
          checks++;
          if (sb[0].size() == 0) begin errors++; $display("FAIL acc_extra_wea @%0d: got write with empty scoreboard", cyc - t); end
          else begin
            e = sb[0].pop_front();
            if (cyc !== e.cyc || wr_addr_g[0] !== e.addr || wd0_g[0] !== e.d0 || wd1_g[0] !== e.d1) begin
              errors++;
              $display("FAIL acc_write(acc=%0b): got cyc=%0d addr=%0d d0=%0d d1=%0d required cyc=%0d addr=%0d d0=%0d d1=%0d",
                       acc, cyc - t, wr_addr_g[0], wd0_g[0], wd1_g[0], e.cyc - t, e.addr, e.d0, e.d1);
            end
          end
        end
        @(negedge clk);
      end
      checks++; if (nwe != HALF) begin errors++; $display("FAIL acc_wea_count: got %0d required %0d", nwe, HALF); end
      sb[0].delete();
      wait_idle();
    end
  endtask

  task automatic test_bf_latency();
    int t, end_c;
    int nwe [NI];
    int ndone [NI];
    exp_t e;
    set_pattern(3);
    start = 1'b1; t = cyc;
    for (int i = 0; i < NI; i++) begin
      push_run(i, t, 1'b0);
      nwe[i] = 0; ndone[i] = 0;
    end
    @(negedge clk);
    start = 1'b0;
    end_c = t + HALF + lat(2) + 3;
    while (cyc <= end_c) begin
      for (int i = 0; i < NI; i++) begin
        if (dn_g[i]) begin
          ndone[i]++;
          checks++; if (cyc != t + HALF + lat(i) + 1) begin errors++; $display("FAIL lat_done_cycle[%0d]: got %0d required %0d", i, cyc - t, HALF + lat(i) + 1); end
        end
        if (wea_g[i]) begin
          nwe[i]++;
          checks++;
          if (sb[i].size() == 0) begin errors++; $display("FAIL lat_extra_wea[%0d] @%0d: got write with empty scoreboard", i, cyc - t); end
          else begin
            e = sb[i].pop_front();
            if (cyc !== e.cyc || wr_addr_g[i] !== e.addr || wd0_g[i] !== e.d0 || wd1_g[i] !== e.d1) begin
              errors++;
              $display("FAIL lat_write[%0d]: got cyc=%0d addr=%0d d0=%0d d1=%0d required cyc=%0d addr=%0d d0=%0d d1=%0d",
                       i, cyc - t, wr_addr_g[i], wd0_g[i], wd1_g[i], e.cyc - t, e.addr, e.d0, e.d1);
            end
          end
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      checks++; if (nwe[i] != HALF) begin errors++; $display("FAIL lat_wea_count[%0d]: got %0d required %0d", i, nwe[i], HALF); end
      checks++; if (ndone[i] != 1) begin errors++; $display("FAIL lat_done_count[%0d]: got %0d required 1", i, ndone[i]); end
      sb[i].delete();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    wait_idle();
    test_basic();
    wait_idle();
    test_start_during_run();
    wait_idle();
    test_reset_mid_run();
    wait_idle();
    test_accumulate();
    test_bf_latency();
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
